// File: rtl/rv32i_mem_stage_if.sv
// Pipelined-Wishbone data bus between the memory stage (master) and data memory (slave).
interface rv32i_mem_stage_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        ack;
  logic        stall;
  logic [31:0] rdata;

  modport master (output cyc, stb, we, addr, wdata, sel, input ack, stall, rdata);
  modport slave  (input cyc, stb, we, addr, wdata, sel, output ack, stall, rdata);
endinterface

// File: rtl/rv32i_mem_stage.sv
// RV32I memory-access stage: one pipelined-Wishbone transaction per LOAD/STORE, others pass through.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned LH/LW/SH/SW trap instead of bus access).
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif
`ifndef STALL_WIDTH
`define STALL_WIDTH 5
`endif
`ifndef LOAD
`define LOAD 0
`endif
`ifndef STORE
`define STORE 1
`endif
`ifndef WRITEBACK
`define WRITEBACK 4
`endif

// state | meaning
// IDLE  | no bus cycle; non-memory ops flow through in one cycle
// REQ   | cyc+stb asserted, waiting for slave to accept (stall low)
// WAIT  | request accepted, cyc held until ack
module rv32i_mem_stage (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [`OPCODE_WIDTH-1:0]    i_opcode,
  input  logic [2:0]                  i_funct3,
  input  logic [31:0]                 i_y,
  input  logic [31:0]                 i_rs2,
  input  logic [4:0]                  i_rd_addr,
  input  logic [31:0]                 i_rd,
  input  logic                        i_rd_valid,
  input  logic                        i_wr_rd,
  input  logic [31:0]                 i_pc,
  input  logic [`EXCEPTION_WIDTH-1:0] i_exception,
  output logic [`OPCODE_WIDTH-1:0]    o_opcode,
  output logic [2:0]                  o_funct3,
  output logic [4:0]                  o_rd_addr,
  output logic [31:0]                 o_rd,
  output logic                        o_rd_valid,
  output logic                        o_wr_rd,
  output logic [31:0]                 o_pc,
  output logic [`EXCEPTION_WIDTH-1:0] o_exception,
  output logic [31:0]                 o_data_load,
  output logic                        o_load_misaligned,
  output logic                        o_store_misaligned,
  rv32i_mem_stage_if.master           wb,
  input  logic                        i_ce,
  output logic                        o_ce,
  input  logic [`STALL_WIDTH-1:0]     i_stall,
  input  logic                        i_force_stall,
  input  logic                        i_flush,
  output logic                        o_stall,
  output logic                        o_flush
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nxt;

  logic        is_load, is_store, misaligned_trap;
  logic        start, completing, stall_bit, wb_stall_in;
  logic        flush_pend;
  logic [1:0]  addr_lo;
  logic [2:0]  req_funct3;
  logic [3:0]  sel_nxt;
  logic [31:0] wdata_nxt, rdata_shift, load_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        unused_stall_bits;

  assign is_load     = i_opcode[`LOAD];
  assign is_store    = i_opcode[`STORE];
  assign wb_stall_in = i_stall[`WRITEBACK];
  assign unused_stall_bits = ^i_stall;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned_trap = (is_load || is_store) &&
                           (((i_funct3[1:0] == 2'b01) && i_y[0]) ||
                            ((i_funct3[1:0] == 2'b10) && (i_y[1:0] != 2'b00)));
`else
  assign misaligned_trap    = 1'b0;
  assign o_load_misaligned  = 1'b0;
  assign o_store_misaligned = 1'b0;
`endif

  assign start = i_ce && (is_load || is_store) && !i_flush && !wb_stall_in &&
                 (state == IDLE) && !misaligned_trap;
  assign completing = wb.ack && (state != IDLE);

  always_comb begin
    o_stall = ((start || (state != IDLE)) && !completing) || wb_stall_in || i_force_stall;
    if (i_flush && (state == IDLE)) o_stall = 1'b0;
  end

  assign o_flush   = i_flush;
  assign stall_bit = o_stall || wb_stall_in;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (wb.ack) state_nxt = IDLE;
               else if (!wb.stall) state_nxt = WAIT;
      WAIT:    if (wb.ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte lanes: sub-word stores are replicated so any selected lane carries the data.
  always_comb begin
    sel_nxt   = 4'b1111;
    wdata_nxt = i_rs2;
    if (is_store) begin
      case (i_funct3[1:0])
        2'b00: begin
          sel_nxt   = 4'b0001 << i_y[1:0];
          wdata_nxt = {4{i_rs2[7:0]}};
        end
        2'b01: begin
          sel_nxt   = i_y[1] ? 4'b1100 : 4'b0011;
          wdata_nxt = {2{i_rs2[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wb.cyc     <= 1'b0;
      wb.stb     <= 1'b0;
      wb.we      <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          wb.cyc <= 1'b1;
          wb.stb <= 1'b1;
          wb.we  <= is_store;
        end
        REQ: begin
          if (wb.ack) begin
            wb.cyc <= 1'b0;
            wb.stb <= 1'b0;
          end else if (!wb.stall) begin
            wb.stb <= 1'b0;
          end
        end
        WAIT: if (wb.ack) wb.cyc <= 1'b0;
        default: ;
      endcase
      if (completing)                         flush_pend <= 1'b0;
      else if (i_flush && (state != IDLE))    flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (start) begin
      wb.addr    <= {i_y[31:2], 2'b00};
      wb.sel     <= sel_nxt;
      wb.wdata   <= wdata_nxt;
      addr_lo    <= i_y[1:0];
      req_funct3 <= i_funct3;
    end
  end

  assign rdata_shift = wb.rdata >> {addr_lo, 3'b000};
  assign ld_byte     = rdata_shift[7:0];
  assign ld_half     = addr_lo[1] ? wb.rdata[31:16] : wb.rdata[15:0];

  always_comb begin
    load_ext = wb.rdata;
    case (req_funct3)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_ext = {24'h0, ld_byte};
      3'b101:  load_ext = {16'h0, ld_half};
      default: load_ext = wb.rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (completing && !wb.we) o_data_load <= load_ext;
  end

  always_ff @(posedge i_clk) begin
    if (i_ce && !stall_bit) begin
      o_opcode   <= i_opcode;
      o_funct3   <= i_funct3;
      o_rd_addr  <= i_rd_addr;
      o_rd       <= i_rd;
      o_rd_valid <= i_rd_valid;
      o_wr_rd    <= i_wr_rd;
      o_pc       <= i_pc;
    end
  end

  // A flush seen during the transaction turns its completion into a bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ce        <= 1'b0;
      o_exception <= '0;
    end else begin
      if (!stall_bit)        o_ce <= i_ce && !i_flush && !flush_pend;
      else if (!wb_stall_in) o_ce <= 1'b0;
      if (i_ce && !stall_bit) o_exception <= i_exception;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_load_misaligned  <= 1'b0;
      o_store_misaligned <= 1'b0;
    end else if (i_ce && !stall_bit) begin
      o_load_misaligned  <= is_load && misaligned_trap;
      o_store_misaligned <= is_store && misaligned_trap;
    end
  end
`endif

endmodule
